// File: rtl/id_imm_ctrl.sv
// id_imm_ctrl: RV64 immediate-format decode with a 2-entry skid buffer toward execute.
// Optional macro ID_IMM_CTRL_PERF_EN adds accept/stall performance counters. Rev 1.0
`default_nettype none

module id_imm_ctrl #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_imm_type,
  output logic            out_illegal
`ifdef ID_IMM_CTRL_PERF_EN
  ,
  output logic [31:0]     perf_accept_cnt,
  output logic [31:0]     perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;

  logic            in_fire;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] dec_imm;
  logic [4:0]      dec_type;
  logic            dec_ill;

  logic [31:0]     main_instr, skid_instr;
  logic [XLEN-1:0] main_pc, skid_pc;
  logic [XLEN-1:0] main_imm, skid_imm;
  logic [4:0]      main_type, skid_type;
  logic            main_ill, skid_ill;

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid & in_ready & ~flush;

  // All formats take their sign from instr[31].
  assign imm_i = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7],
                  in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u = {{(XLEN-32){in_instr[31]}}, in_instr[31:12], 12'b0};
  assign imm_j = {{(XLEN-21){in_instr[31]}}, in_instr[31], in_instr[19:12],
                  in_instr[20], in_instr[30:21], 1'b0};

  always_comb begin
    dec_type = 5'b00000;
    dec_imm  = '0;
    dec_ill  = 1'b0;
    case (in_instr[6:0])
      7'b0000011, 7'b0001111, 7'b0010011,
      7'b0011011, 7'b1100111, 7'b1110011: begin dec_type = 5'b00001; dec_imm = imm_i; end
      7'b0100011:                         begin dec_type = 5'b00010; dec_imm = imm_s; end
      7'b1100011:                         begin dec_type = 5'b00100; dec_imm = imm_b; end
      7'b0010111, 7'b0110111:             begin dec_type = 5'b01000; dec_imm = imm_u; end
      7'b1101111:                         begin dec_type = 5'b10000; dec_imm = imm_j; end
      7'b0110011, 7'b0111011:             dec_type = 5'b00000;
      default:                            dec_ill  = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      main_instr <= '0;
      main_pc    <= '0;
      main_imm   <= '0;
      main_type  <= '0;
      main_ill   <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
      skid_imm   <= '0;
      skid_type  <= '0;
      skid_ill   <= 1'b0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state      <= ONE;
            main_instr <= in_instr;
            main_pc    <= in_pc;
            main_imm   <= dec_imm;
            main_type  <= dec_type;
            main_ill   <= dec_ill;
          end
        end
        ONE: begin
          if (in_fire && out_ready) begin
            main_instr <= in_instr;
            main_pc    <= in_pc;
            main_imm   <= dec_imm;
            main_type  <= dec_type;
            main_ill   <= dec_ill;
          end else if (in_fire) begin
            state      <= FULL;
            skid_instr <= in_instr;
            skid_pc    <= in_pc;
            skid_imm   <= dec_imm;
            skid_type  <= dec_type;
            skid_ill   <= dec_ill;
          end else if (out_ready) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (out_ready) begin
            state      <= ONE;
            main_instr <= skid_instr;
            main_pc    <= skid_pc;
            main_imm   <= skid_imm;
            main_type  <= skid_type;
            main_ill   <= skid_ill;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign out_instr    = main_instr;
  assign out_pc       = main_pc;
  assign out_imm      = main_imm;
  assign out_imm_type = main_type;
  assign out_illegal  = main_ill;

`ifdef ID_IMM_CTRL_PERF_EN
  // Counters ignore flush; a flush cycle never counts as accept or stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_accept_cnt <= '0;
      perf_stall_cnt  <= '0;
    end else begin
      if (in_fire)
        perf_accept_cnt <= perf_accept_cnt + 32'd1;
      if (in_valid && !in_ready && !flush)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_imm_ctrl.sv
// tb_id_imm_ctrl: directed and randomized checks of id_imm_ctrl against a queue-based model.
`default_nettype none

module tb_id_imm_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic [63:0] out_imm;
  logic [4:0]  out_imm_type;
  logic        out_illegal;
`ifdef ID_IMM_CTRL_PERF_EN
  logic [31:0] perf_accept_cnt, perf_stall_cnt;
`endif

  id_imm_ctrl #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_imm(out_imm), .out_imm_type(out_imm_type), .out_illegal(out_illegal)
`ifdef ID_IMM_CTRL_PERF_EN
    , .perf_accept_cnt(perf_accept_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] imm;
    logic [4:0]  typ;
    logic        ill;
  } ent_t;

  ent_t        q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_acc, m_stl;
  logic [63:0] pc_ctr = 64'h0000_0000_8000_0000;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode from the ISA field layout using signed shifts.
  function automatic ent_t model(input logic [31:0] ins, input logic [63:0] pc);
    ent_t        e;
    logic [6:0]  op;
    longint      s;
    op      = ins[6:0];
    s       = longint'($signed(ins));
    e.instr = ins;
    e.pc    = pc;
    e.imm   = 64'd0;
    e.typ   = 5'd0;
    e.ill   = 1'b0;
    if (op inside {7'h03, 7'h0F, 7'h13, 7'h1B, 7'h67, 7'h73}) begin
      e.typ = 5'd1;  e.imm = 64'(s >>> 20);
    end else if (op == 7'h23) begin
      e.typ = 5'd2;  e.imm = 64'((s >>> 25) <<< 5) | 64'(ins[11:7]);
    end else if (op == 7'h63) begin
      e.typ = 5'd4;
      e.imm = 64'((s >>> 31) <<< 12) | (64'(ins[7]) << 11) | (64'(ins[30:25]) << 5) | (64'(ins[11:8]) << 1);
    end else if (op == 7'h17 || op == 7'h37) begin
      e.typ = 5'd8;  e.imm = 64'(longint'($signed(ins & 32'hFFFF_F000)));
    end else if (op == 7'h6F) begin
      e.typ = 5'd16;
      e.imm = 64'((s >>> 31) <<< 20) | (64'(ins[19:12]) << 12) | (64'(ins[20]) << 11) | (64'(ins[30:21]) << 1);
    end else if (op == 7'h33 || op == 7'h3B) begin
      e.typ = 5'd0;
    end else begin
      e.ill = 1'b1;
    end
    return e;
  endfunction

  logic m_rdy, m_fire;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_acc = 32'd0;
      m_stl = 32'd0;
    end else begin
      m_rdy  = (q.size() < 2);
      m_fire = in_valid & m_rdy & ~flush;
      if (m_fire) m_acc = m_acc + 32'd1;
      if (in_valid && !m_rdy && !flush) m_stl = m_stl + 32'd1;
      if (flush) q.delete();
      else begin
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (m_fire) q.push_back(model(in_instr, in_pc));
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk("out_instr", 64'(out_instr), 64'(q[0].instr));
      chk("out_pc", out_pc, q[0].pc);
      chk("out_imm", out_imm, q[0].imm);
      chk("out_imm_type", 64'(out_imm_type), 64'(q[0].typ));
      chk("out_illegal", 64'(out_illegal), 64'(q[0].ill));
    end
`ifdef ID_IMM_CTRL_PERF_EN
    chk("perf_accept", 64'(perf_accept_cnt), 64'(m_acc));
    chk("perf_stall", 64'(perf_stall_cnt), 64'(m_stl));
`endif
  end

  // Drives one cycle of inputs just after a falling edge, returns at the next falling edge.
  task automatic cyc(input logic v, input logic [31:0] ins, input logic ordy, input logic fl);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc_ctr;
    out_ready = ordy;
    flush     = fl;
    pc_ctr    = pc_ctr + 64'd4;
    @(negedge clk);
  endtask

  task automatic lit(input string name, input logic [63:0] imm, input logic [4:0] typ, input logic ill);
    chk({name, "_valid"}, 64'(out_valid), 64'd1);
    chk({name, "_imm"}, out_imm, imm);
    chk({name, "_type"}, 64'(out_imm_type), 64'(typ));
    chk({name, "_ill"}, 64'(out_illegal), 64'(ill));
  endtask

  logic [6:0]  ops[15] = '{7'h03, 7'h0F, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h23, 7'h63,
                           7'h17, 7'h37, 7'h6F, 7'h33, 7'h3B, 7'h00, 7'h2B};
  logic [31:0] rnd;

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_instr", 64'(out_instr), 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_out_imm", out_imm, 64'd0);
    chk("rst_out_type", 64'(out_imm_type), 64'd0);
    chk("rst_out_ill", 64'(out_illegal), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    cyc(1, 32'hFFF0_0093, 1, 0); lit("addi", 64'hFFFF_FFFF_FFFF_FFFF, 5'b00001, 0);
    cyc(1, 32'h0011_3423, 1, 0); lit("sd",   64'h8, 5'b00010, 0);
    cyc(1, 32'hFE00_0EE3, 1, 0); lit("beq",  64'hFFFF_FFFF_FFFF_FFFC, 5'b00100, 0);
    cyc(1, 32'h1234_5037, 1, 0); lit("lui",  64'h0000_0000_1234_5000, 5'b01000, 0);
    cyc(1, 32'h0000_006F, 1, 0); lit("jal",  64'h0, 5'b10000, 0);
    cyc(1, 32'h0000_0000, 1, 0); lit("zero", 64'h0, 5'b00000, 1);
    cyc(1, 32'h0000_0033, 1, 0); lit("add",  64'h0, 5'b00000, 0);
    cyc(0, 32'h0, 1, 0);         chk("drain_valid", 64'(out_valid), 64'd0);

    // Backpressure: A,B fill the buffer, C waits upstream.
    cyc(1, 32'h0050_0093, 0, 0); chk("bp_rdy1", 64'(in_ready), 64'd1);
    cyc(1, 32'h00A0_0113, 0, 0); chk("bp_rdy2", 64'(in_ready), 64'd0);
    cyc(1, 32'h00F0_0193, 0, 0); chk("bp_held", 64'(out_instr), 64'h0050_0093);
    cyc(1, 32'h00F0_0193, 1, 0); chk("bp_B", 64'(out_instr), 64'h00A0_0113);
    chk("bp_rdy3", 64'(in_ready), 64'd1);
    cyc(1, 32'h00F0_0193, 1, 0); chk("bp_C", 64'(out_instr), 64'h00F0_0193);
    cyc(0, 32'h0, 1, 0);         chk("bp_empty", 64'(out_valid), 64'd0);

    // Flush from FULL with a valid input on the flush cycle.
    cyc(1, 32'h0050_0093, 0, 0);
    cyc(1, 32'h00A0_0113, 0, 0);
    cyc(1, 32'h00F0_0193, 0, 1); chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_rdy", 64'(in_ready), 64'd1);
    cyc(0, 32'h0, 1, 0);         chk("fl_dropped", 64'(out_valid), 64'd0);

    for (int i = 0; i < 2000; i++) begin
      rnd = $urandom();
      if ($urandom_range(7) == 0) in_instr = $urandom();
      else in_instr = {rnd[31:7], ops[$urandom_range(14)]};
      pc_ctr = {$urandom(), $urandom()};
      cyc($urandom_range(3) != 0, in_instr, $urandom_range(2) != 0, $urandom_range(19) == 0);
    end

    // Asynchronous reset with entries held.
    cyc(1, 32'h0050_0093, 0, 0);
    cyc(1, 32'h00A0_0113, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_rdy", 64'(in_ready), 64'd1);
    chk("arst_instr", 64'(out_instr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 32'h0, 1, 0);
    chk("arst_after", 64'(out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/id_imm_ctrl.md
Name: id_imm_ctrl

Overview:
- Decode-side controller for the RV64 immediate generator.
- Accepts a fetched instruction and PC over a valid/ready handshake and classifies the opcode into one-hot immediate-format selects (I/S/B/U/J).
- Forms the sign-extended immediate and presents the result registered to the execute stage through a 2-entry skid buffer, with flush and illegal-opcode flagging.

Parameters:
XLEN, 64, width of PC and immediate; only 64 is supported.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous pipeline flush; highest priority
in_valid  input  1  upstream instruction valid
in_ready  output  1  block can accept
in_instr  input  32  instruction word
in_pc  input  XLEN  instruction PC
out_valid  output  1  result valid
out_ready  input  1  downstream accepts
out_instr  output  32  registered instruction
out_pc  output  XLEN  registered PC
out_imm  output  XLEN  sign-extended immediate
out_imm_type  output  5  one-hot {J,U,B,S,I} (bit0=I); 0 = no immediate
out_illegal  output  1  opcode not recognised

Behaviour:
- Handshake events:
  - in_fire = in_valid & in_ready & ~flush.
  - out_fire = out_valid & out_ready.
- Decode is combinational on the input side (in_instr[6:0]); the result is captured on in_fire. Latency is 1 cycle from in_fire to out_valid when the buffer is empty.
- Opcode classes:
  - I: 0000011, 0001111, 0010011, 0011011, 1100111, 1110011.
  - S: 0100011.
  - B: 1100011.
  - U: 0010111, 0110111.
  - J: 1101111.
  - R (type=0, imm=0, legal): 0110011, 0111011.
  - Anything else, or instr[1:0]!=2'b11: illegal, type=0, imm=0, out_illegal=1.
- Immediate per RV64 formats; sign bit is instr[31] for all formats:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}, sign-extended.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- Buffer FSM, states EMPTY, ONE, FULL:
  - EMPTY: in_fire -> ONE, main <= in.
  - ONE, in_fire & out_fire: stay ONE, main <= in.
  - ONE, in_fire & ~out_ready: -> FULL, skid <= in.
  - ONE, out_fire & ~in_fire: -> EMPTY.
  - FULL: no input accepted; out_fire -> ONE, main <= skid.
  - flush (any state): -> EMPTY next cycle; both entries discarded; no input accepted that cycle.
- Output relations:
  - in_ready = (state != FULL), decoded from the state register only; no combinational path from out_ready.
  - out_valid = (state != EMPTY); out_* always reflect the main entry.
  - Ordering is strictly FIFO; no instruction is dropped or duplicated except by flush.
- Reset (rst_n low, async): state EMPTY; out_valid=0, out_instr=0, out_pc=0, out_imm=0, out_imm_type=0, out_illegal=0, in_ready=1; skid contents cleared.
- Reset mid-transfer discards all held entries.

Optional Feature:
- Macro ID_IMM_CTRL_PERF_EN.
- When defined, adds outputs perf_accept_cnt[31:0] (increments on in_fire) and perf_stall_cnt[31:0] (increments each cycle with in_valid & ~in_ready).
- Both counters wrap at 2^32, clear on reset, are not affected by flush, and do not count in_valid during a flush cycle.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFFFFFFFFFF, out_imm_type=5'b00001, out_illegal=0.
- 0x00113423 (sd x1,8(x2)) then 0xFE000EE3 (beq -4) back-to-back -> out_imm=0x8 type 5'b00010, then 0xFFFFFFFFFFFFFFFC type 5'b00100, one per cycle.
- 0x12345037 (lui) -> out_imm=0x0000000012345000, type 5'b01000; 0x0000006F (jal 0) -> imm 0, type 5'b10000.
- out_ready=0, push A,B -> in_ready=0 after B, C held upstream; raise out_ready -> A,B,C emerge in order, in_ready returns to 1.
- Buffer FULL, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, input of flush cycle not seen at output.
- 0x00000000 and 0x00000033 (add) -> first out_illegal=1, type 0, imm 0; second out_illegal=0, type 0, imm 0.
